requant_sched: RTL

- Per-channel sequencer for the requantize/activation datapath.
- On `start`, for each output channel it:
  - reads that channel's quantization parameters from the parameter RAM,
  - accepts one accumulator value from the MAC array,
  - drives the datapath and holds its inputs stable until the result is valid,
  - packs the 8-bit results four per 32-bit word for the writeback path.
- Sits between the MAC accumulator output, the parameter RAM and the output-tensor write FIFO.

---
 rtl/requant_sched.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/requant_sched.sv
// requant_sched: per-channel sequencer for the requantize/activation datapath.
// Fetches per-channel quantization parameters, takes one accumulator value per
// channel, holds the datapath operands steady for the whole pipeline latency
// and packs the 8-bit results four per 32-bit word (byte0 = lowest channel).
// Optional performance counters are enabled by defining REQUANT_SCHED_PERF_EN.
module requant_sched #(
    parameter int PIPE_LAT = 3,
    parameter int CH_W     = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CH_W-1:0] num_ch,
    output logic            busy,
    output logic            done,
    output logic            prm_rd,
    output logic [CH_W-1:0] prm_addr,
    input  logic [127:0]    prm_rdata,
    input  logic            acc_valid,
    output logic            acc_ready,
    input  logic [31:0]     acc_data,
    output logic            dp_act_en,
    output logic [31:0]     dp_res_in,
    output logic [31:0]     dp_multi,
    output logic [31:0]     dp_shifts,
    output logic [31:0]     dp_bias,
    output logic [31:0]     dp_row_sum,
    input  logic [7:0]      dp_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data
`ifdef REQUANT_SCHED_PERF_EN
    ,
    output logic [31:0]     perf_busy_cyc,
    output logic [31:0]     perf_stall_cyc
`endif
);

    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PLAT,
        ACC,
        RUN,
        FLUSH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   num_ch_q;
    logic [1:0]        bytecnt;
    logic [31:0]       pack;
    logic [CNT_W-1:0]  wait_cnt;

    logic              pending;
    logic              word_take;
    logic              acc_fire;
    logic              capture;
    logic              last_ch;
    logic              flush_load;
    logic              flush_done;

    // A word that has not been accepted yet blocks the next accumulator.
    assign pending    = out_valid && !out_ready;
    assign word_take  = out_valid && out_ready;
    assign acc_fire   = (state == ACC) && acc_valid && acc_ready;
    assign capture    = (state == RUN) && (wait_cnt == LAST_CNT);
    assign last_ch    = (ch == (num_ch_q - CH_W'(1)));
    assign flush_load = (state == FLUSH) && (bytecnt != 2'd0) && !out_valid;
    assign flush_done = (state == FLUSH) && (bytecnt == 2'd0) && (!out_valid || out_ready);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake/strobe outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        prm_rd    = 1'b0;
        prm_addr  = '0;
        acc_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start && (num_ch != '0)) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                prm_rd    = 1'b1;
                prm_addr  = ch;
                state_nxt = PLAT;
            end
            PLAT: begin
                state_nxt = ACC;
            end
            ACC: begin
                acc_ready = !pending;
                if (acc_valid && !pending) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (capture) begin
                    state_nxt = last_ch ? FLUSH : FETCH;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Channel bookkeeping, operand registers, packing and the output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch         <= '0;
            num_ch_q   <= '0;
            bytecnt    <= 2'd0;
            pack       <= '0;
            wait_cnt   <= '0;
            done       <= 1'b0;
            dp_act_en  <= 1'b0;
            dp_res_in  <= '0;
            dp_multi   <= '0;
            dp_shifts  <= '0;
            dp_bias    <= '0;
            dp_row_sum <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            done <= 1'b0;

            if ((state == IDLE) && start) begin
                ch       <= '0;
                num_ch_q <= num_ch;
                done     <= (num_ch == '0);
            end

            if (state == PLAT) begin
                {dp_row_sum, dp_bias, dp_shifts, dp_multi} <= prm_rdata;
            end

            if (acc_fire) begin
                dp_res_in <= acc_data;
                dp_act_en <= 1'b1;
                wait_cnt  <= '0;
            end

            if (state == RUN) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (word_take) begin
                out_valid <= 1'b0;
            end

            if (capture) begin
                dp_act_en <= 1'b0;
                bytecnt   <= bytecnt + 2'd1;
                if (bytecnt == 2'd3) begin
                    out_data  <= {dp_result, pack[23:0]};
                    out_valid <= 1'b1;
                    pack      <= '0;
                end else begin
                    pack[{bytecnt, 3'b000} +: 8] <= dp_result;
                end
                if (!last_ch) begin
                    ch <= ch + CH_W'(1);
                end
            end

            // Partial last word: unused upper bytes are already zero.
            if (flush_load) begin
                out_data  <= pack;
                out_valid <= 1'b1;
                pack      <= '0;
                bytecnt   <= 2'd0;
            end

            if (flush_done) begin
                done <= 1'b1;
            end
        end
    end

`ifdef REQUANT_SCHED_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Busy and accumulator-stall cycle counters, cleared on each start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if ((state == IDLE) && start) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy) begin
                perf_busy_cyc <= sat_inc(perf_busy_cyc);
            end
            if ((state == ACC) && (!acc_ready || !acc_valid)) begin
                perf_stall_cyc <= sat_inc(perf_stall_cyc);
            end
        end
    end
`endif

endmodule
